// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - next-PC select with a direct-mapped 2-bit branch history table
// Lookups read the table state before this cycle's resolve is written into it.
module next_pc_unit #(
  parameter int BHT_IDX_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        res_valid_i,
  input  logic [31:0] res_pc_i,
  input  logic        res_taken_i,
  input  logic [31:0] res_target_i,
  input  logic        res_pred_taken_i,
  input  logic [31:0] res_pred_target_i,
  output logic [31:0] pc_next_o,
  output logic        pc_write_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  output logic        flush_o,
  output logic [15:0] mispred_cnt_o
);

  localparam int N     = 1 << BHT_IDX_W;
  localparam int TAG_W = 32 - BHT_IDX_W - 2;

  logic [1:0]       cnt_q   [N];
  logic [1:0]       cnt_d   [N];
  logic [TAG_W-1:0] tag_q   [N];
  logic [TAG_W-1:0] tag_d   [N];
  logic [31:0]      tgt_q   [N];
  logic [31:0]      tgt_d   [N];
  logic [N-1:0]     valid_q;
  logic [N-1:0]     valid_d;
  logic [15:0]      mcnt_q;
  logic [15:0]      mcnt_d;

  logic [BHT_IDX_W-1:0] lk_idx;
  logic [BHT_IDX_W-1:0] up_idx;
  logic                 lk_hit;
  logic                 up_hit;
  logic                 mispredict;
  logic                 unused_pc_lsbs;

  assign unused_pc_lsbs = ^{pc_i[1:0], res_pc_i[1:0]};

  always_comb begin
    lk_idx        = pc_i[BHT_IDX_W+1:2];
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == pc_i[31:BHT_IDX_W+2]);
    pred_target_o = lk_hit ? tgt_q[lk_idx] : pc_i + 32'd4;
    pred_taken_o  = !rst_i && lk_hit && cnt_q[lk_idx][1];

    mispredict = res_valid_i &&
                 ((res_taken_i != res_pred_taken_i) ||
                  (res_taken_i && (res_target_i != res_pred_target_i)));

    // A redirect from EX outranks a hazard stall.
    pc_next_o  = pred_target_o;
    pc_write_o = 1'b1;
    flush_o    = 1'b0;
    if (rst_i) begin
      pc_next_o  = 32'd0;
      pc_write_o = 1'b0;
    end else if (mispredict) begin
      pc_next_o = res_taken_i ? res_target_i : res_pc_i + 32'd4;
      flush_o   = 1'b1;
    end else if (stall_i) begin
      pc_next_o  = pc_i;
      pc_write_o = 1'b0;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    valid_d = valid_q;
    up_idx  = res_pc_i[BHT_IDX_W+1:2];
    up_hit  = valid_q[up_idx] && (tag_q[up_idx] == res_pc_i[31:BHT_IDX_W+2]);
    if (res_valid_i) begin
      if (up_hit) begin
        if (res_taken_i) begin
          cnt_d[up_idx] = (cnt_q[up_idx] == 2'd3) ? 2'd3 : cnt_q[up_idx] + 2'd1;
          tgt_d[up_idx] = res_target_i;
        end else begin
          cnt_d[up_idx] = (cnt_q[up_idx] == 2'd0) ? 2'd0 : cnt_q[up_idx] - 2'd1;
        end
      end else if (res_taken_i) begin
        // Allocate on a taken miss; a not-taken miss has nothing worth storing.
        cnt_d[up_idx]   = 2'd2;
        tag_d[up_idx]   = res_pc_i[31:BHT_IDX_W+2];
        tgt_d[up_idx]   = res_target_i;
        valid_d[up_idx] = 1'b1;
      end
    end
    mcnt_d = (mispredict && (mcnt_q != 16'hFFFF)) ? mcnt_q + 16'd1 : mcnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      mcnt_q  <= 16'd0;
      for (int i = 0; i < N; i++) cnt_q[i] <= 2'b01;
    end else begin
      valid_q <= valid_d;
      mcnt_q  <= mcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tags and targets are only meaningful behind a valid bit, so they skip reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      tag_q <= tag_d;
      tgt_q <= tgt_d;
    end
  end

  assign mispred_cnt_o = mcnt_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// tb/tb_next_pc_unit.sv - scoreboard bench for next_pc_unit
module tb_next_pc_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        stall_i;
  logic        res_valid_i;
  logic [31:0] res_pc_i;
  logic        res_taken_i;
  logic [31:0] res_target_i;
  logic        res_pred_taken_i;
  logic [31:0] res_pred_target_i;
  logic [31:0] pc_next_o;
  logic        pc_write_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        flush_o;
  logic [15:0] mispred_cnt_o;

  always #5 clk_i = ~clk_i;

  next_pc_unit #(.BHT_IDX_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .stall_i(stall_i),
    .res_valid_i(res_valid_i), .res_pc_i(res_pc_i), .res_taken_i(res_taken_i),
    .res_target_i(res_target_i), .res_pred_taken_i(res_pred_taken_i),
    .res_pred_target_i(res_pred_target_i), .pc_next_o(pc_next_o),
    .pc_write_o(pc_write_o), .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o), .flush_o(flush_o), .mispred_cnt_o(mispred_cnt_o)
  );

  typedef struct packed {
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        rt;
    logic [31:0] rtgt;
    logic        rpt;
    logic [31:0] rptgt;
  } stim_t;

  typedef struct packed {
    logic [31:0] next;
    logic        wr;
    logic        flush;
    logic        pt;
    logic [31:0] ptgt;
    logic [15:0] mcnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic stim_t mk_s(input logic rst, input logic [31:0] pc, input logic stall,
                                 input logic rv, input logic [31:0] rpc, input logic rt,
                                 input logic [31:0] rtgt, input logic rpt,
                                 input logic [31:0] rptgt);
    return '{rst, pc, stall, rv, rpc, rt, rtgt, rpt, rptgt};
  endfunction

  function automatic exp_t mk_e(input logic [31:0] next, input logic wr, input logic flush,
                                input logic pt, input logic [31:0] ptgt, input logic [15:0] mcnt);
    return '{next, wr, flush, pt, ptgt, mcnt};
  endfunction

  task automatic drive(input stim_t s);
    @(posedge clk_i);
    #1;
    rst_i             = s.rst;
    pc_i              = s.pc;
    stall_i           = s.stall;
    res_valid_i       = s.rv;
    res_pc_i          = s.rpc;
    res_taken_i       = s.rt;
    res_target_i      = s.rtgt;
    res_pred_taken_i  = s.rpt;
    res_pred_target_i = s.rptgt;
  endtask

  function automatic exp_t observe();
    return '{pc_next_o, pc_write_o, flush_o, pred_taken_o, pred_target_o, mispred_cnt_o};
  endfunction

  task automatic test_reset();
    stim_t s[1];
    exp_t  e[1];
    exp_t  got, want;
    s[0] = mk_s(1, 32'h100, 0, 1, 32'h100, 1, 32'h200, 0, 32'h104);
    e[0] = mk_e(32'h0, 0, 0, 0, 32'h104, 16'd0);
    for (int i = 0; i < 1; i++) begin
      drive(s[i]); sb.push_back(e[i]);
      @(negedge clk_i);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset[%0d] got next=%h wr=%b fl=%b pt=%b tgt=%h cnt=%h want next=%h wr=%b fl=%b pt=%b tgt=%h cnt=%h",
                 i, got.next, got.wr, got.flush, got.pt, got.ptgt, got.mcnt,
                 want.next, want.wr, want.flush, want.pt, want.ptgt, want.mcnt);
      end
    end
  endtask

  task automatic test_train();
    stim_t s[3];
    exp_t  e[3];
    exp_t  got, want;
    s[0] = mk_s(0, 32'h100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    e[0] = mk_e(32'h104, 1, 0, 0, 32'h104, 16'd0);
    s[1] = mk_s(0, 32'h100, 0, 1, 32'h100, 1, 32'h200, 0, 32'h104);
    e[1] = mk_e(32'h200, 1, 1, 0, 32'h104, 16'd0);
    s[2] = mk_s(0, 32'h100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    e[2] = mk_e(32'h200, 1, 0, 1, 32'h200, 16'd1);
    for (int i = 0; i < 3; i++) begin
      drive(s[i]); sb.push_back(e[i]);
      @(negedge clk_i);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL train[%0d] got next=%h wr=%b fl=%b pt=%b tgt=%h cnt=%h want next=%h wr=%b fl=%b pt=%b tgt=%h cnt=%h",
                 i, got.next, got.wr, got.flush, got.pt, got.ptgt, got.mcnt,
                 want.next, want.wr, want.flush, want.pt, want.ptgt, want.mcnt);
      end
    end
  endtask

  task automatic test_saturation();
    stim_t s[7];
    exp_t  e[7];
    exp_t  got, want;
    s[0] = mk_s(0, 32'h100, 0, 1, 32'h100, 1, 32'h200, 1, 32'h200);
    e[0] = mk_e(32'h200, 1, 0, 1, 32'h200, 16'd1);
    s[1] = mk_s(0, 32'h100, 0, 1, 32'h100, 0, 32'h0, 1, 32'h200);
    e[1] = mk_e(32'h104, 1, 1, 1, 32'h200, 16'd1);
    s[2] = mk_s(0, 32'h100, 0, 1, 32'h100, 0, 32'h0, 1, 32'h200);
    e[2] = mk_e(32'h104, 1, 1, 1, 32'h200, 16'd2);
    s[3] = mk_s(0, 32'h100, 0, 1, 32'h100, 0, 32'h0, 0, 32'h200);
    e[3] = mk_e(32'h200, 1, 0, 0, 32'h200, 16'd3);
    s[4] = mk_s(0, 32'h100, 0, 1, 32'h100, 0, 32'h0, 0, 32'h200);
    e[4] = mk_e(32'h200, 1, 0, 0, 32'h200, 16'd3);
    s[5] = mk_s(0, 32'h100, 0, 1, 32'h100, 1, 32'h200, 0, 32'h200);
    e[5] = mk_e(32'h200, 1, 1, 0, 32'h200, 16'd3);
    s[6] = mk_s(0, 32'h100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    e[6] = mk_e(32'h200, 1, 0, 0, 32'h200, 16'd4);
    for (int i = 0; i < 7; i++) begin
      drive(s[i]); sb.push_back(e[i]);
      @(negedge clk_i);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL saturation[%0d] got next=%h wr=%b fl=%b pt=%b tgt=%h cnt=%h want next=%h wr=%b fl=%b pt=%b tgt=%h cnt=%h",
                 i, got.next, got.wr, got.flush, got.pt, got.ptgt, got.mcnt,
                 want.next, want.wr, want.flush, want.pt, want.ptgt, want.mcnt);
      end
    end
  endtask

  task automatic test_stall();
    stim_t s[3];
    exp_t  e[3];
    exp_t  got, want;
    s[0] = mk_s(0, 32'h180, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    e[0] = mk_e(32'h180, 0, 0, 0, 32'h184, 16'd4);
    s[1] = mk_s(0, 32'h180, 1, 1, 32'h300, 0, 32'h0, 1, 32'h340);
    e[1] = mk_e(32'h304, 1, 1, 0, 32'h184, 16'd4);
    s[2] = mk_s(0, 32'h100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    e[2] = mk_e(32'h200, 1, 0, 0, 32'h200, 16'd5);
    for (int i = 0; i < 3; i++) begin
      drive(s[i]); sb.push_back(e[i]);
      @(negedge clk_i);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL stall[%0d] got next=%h wr=%b fl=%b pt=%b tgt=%h cnt=%h want next=%h wr=%b fl=%b pt=%b tgt=%h cnt=%h",
                 i, got.next, got.wr, got.flush, got.pt, got.ptgt, got.mcnt,
                 want.next, want.wr, want.flush, want.pt, want.ptgt, want.mcnt);
      end
    end
  endtask

  task automatic test_wrong_target();
    stim_t s[3];
    exp_t  e[3];
    exp_t  got, want;
    s[0] = mk_s(0, 32'h104, 0, 1, 32'h104, 1, 32'h200, 0, 32'h108);
    e[0] = mk_e(32'h200, 1, 1, 0, 32'h108, 16'd5);
    s[1] = mk_s(0, 32'h104, 0, 1, 32'h104, 1, 32'h240, 1, 32'h200);
    e[1] = mk_e(32'h240, 1, 1, 1, 32'h200, 16'd6);
    s[2] = mk_s(0, 32'h104, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    e[2] = mk_e(32'h240, 1, 0, 1, 32'h240, 16'd7);
    for (int i = 0; i < 3; i++) begin
      drive(s[i]); sb.push_back(e[i]);
      @(negedge clk_i);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL wrong_target[%0d] got next=%h wr=%b fl=%b pt=%b tgt=%h cnt=%h want next=%h wr=%b fl=%b pt=%b tgt=%h cnt=%h",
                 i, got.next, got.wr, got.flush, got.pt, got.ptgt, got.mcnt,
                 want.next, want.wr, want.flush, want.pt, want.ptgt, want.mcnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s[2];
    exp_t  e[2];
    exp_t  got, want;
    s[0] = mk_s(1, 32'h104, 0, 1, 32'h104, 1, 32'h280, 1, 32'h240);
    e[0] = mk_e(32'h0, 0, 0, 0, 32'h240, 16'd7);
    s[1] = mk_s(0, 32'h104, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    e[1] = mk_e(32'h108, 1, 0, 0, 32'h108, 16'd0);
    for (int i = 0; i < 2; i++) begin
      drive(s[i]); sb.push_back(e[i]);
      @(negedge clk_i);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset_mid[%0d] got next=%h wr=%b fl=%b pt=%b tgt=%h cnt=%h want next=%h wr=%b fl=%b pt=%b tgt=%h cnt=%h",
                 i, got.next, got.wr, got.flush, got.pt, got.ptgt, got.mcnt,
                 want.next, want.wr, want.flush, want.pt, want.ptgt, want.mcnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[4];
    exp_t  e[4];
    exp_t  got, want;
    s[0] = mk_s(0, 32'h108, 0, 1, 32'h108, 1, 32'h400, 0, 32'h10C);
    e[0] = mk_e(32'h400, 1, 1, 0, 32'h10C, 16'd0);
    s[1] = mk_s(0, 32'h108, 0, 1, 32'h108, 1, 32'h400, 1, 32'h400);
    e[1] = mk_e(32'h400, 1, 0, 1, 32'h400, 16'd1);
    s[2] = mk_s(0, 32'h108, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    e[2] = mk_e(32'h400, 1, 0, 1, 32'h400, 16'd1);
    s[3] = mk_s(0, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    e[3] = mk_e(32'h0, 1, 0, 0, 32'h0, 16'd1);
    for (int i = 0; i < 4; i++) begin
      drive(s[i]); sb.push_back(e[i]);
      @(negedge clk_i);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL back_to_back[%0d] got next=%h wr=%b fl=%b pt=%b tgt=%h cnt=%h want next=%h wr=%b fl=%b pt=%b tgt=%h cnt=%h",
                 i, got.next, got.wr, got.flush, got.pt, got.ptgt, got.mcnt,
                 want.next, want.wr, want.flush, want.pt, want.ptgt, want.mcnt);
      end
    end
  endtask

  initial begin
    rst_i             = 1'b1;
    pc_i              = 32'h0;
    stall_i           = 1'b0;
    res_valid_i       = 1'b0;
    res_pc_i          = 32'h0;
    res_taken_i       = 1'b0;
    res_target_i      = 32'h0;
    res_pred_taken_i  = 1'b0;
    res_pred_target_i = 32'h0;
    test_reset();
    test_train();
    test_saturation();
    test_stall();
    test_wrong_target();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk_i and rst_i; all state updates on posedge clk_i.
REQ-002 SHALL use parameter BHT_IDX_W, default 4, giving 2^BHT_IDX_W table entries indexed by pc[BHT_IDX_W+1:2].
REQ-003 SHALL provide port clk_i  input  1  system clock.
REQ-004 SHALL provide port rst_i  input  1  synchronous active-high reset.
REQ-005 SHALL provide port pc_i  input  32  current PC from the PC register.
REQ-006 SHALL provide port stall_i  input  1  hazard stall request; hold PC.
REQ-007 SHALL provide port res_valid_i  input  1  branch resolved this cycle (from EX).
REQ-008 SHALL provide port res_pc_i  input  32  PC of the resolved branch.
REQ-009 SHALL provide port res_taken_i  input  1  actual branch direction.
REQ-010 SHALL provide port res_target_i  input  32  actual taken target.
REQ-011 SHALL provide port res_pred_taken_i  input  1  prediction carried down the pipe with that branch.
REQ-012 SHALL provide port res_pred_target_i  input  32  predicted target carried down the pipe.
REQ-013 SHALL provide port pc_next_o  output  32  value for the PC register's pc_in_i.
REQ-014 SHALL provide port pc_write_o  output  1  drives the PC register's select.
REQ-015 SHALL provide port pred_taken_o  output  1  prediction for pc_i.
REQ-016 SHALL provide port pred_target_o  output  32  predicted target for pc_i.
REQ-017 SHALL provide port flush_o  output  1  squash IF/ID and ID/EX this cycle.
REQ-018 SHALL provide port mispred_cnt_o  output  16  saturating misprediction count.

Function
REQ-019 SHALL hold per entry: 2-bit counter, valid bit, tag pc[31:BHT_IDX_W+2], 32-bit target.
REQ-020 SHALL look up combinationally from pc_i in the same cycle: hit = valid and tag match; pred_taken_o = hit and counter >= 2.
REQ-021 SHALL drive pred_target_o = entry target on hit, else pc_i+4; all sums 32-bit, wrapping modulo 2^32.
REQ-022 SHALL define mispredict = res_valid_i and (res_taken_i != res_pred_taken_i, or res_taken_i and res_target_i != res_pred_target_i).
REQ-023 SHALL apply this priority to pc_next_o / pc_write_o / flush_o:
  - mispredict: res_taken_i ? res_target_i : res_pc_i+4 / 1 / 1
  - else stall_i: pc_next_o = pc_i / 0 / 0
  - else: pred_target_o / 1 / 0
REQ-024 SHALL honour a redirect regardless of stall_i when mispredict and stall_i are both asserted.
REQ-025 SHALL, on res_valid_i, update the entry at res_pc_i's index on the next edge:
  - counter +1 if taken, -1 if not, saturating at 3 and 0
  - on taken: write tag and target, set valid
  - on not-taken: keep tag, target and valid
REQ-026 SHALL, for a tag miss on update, write tag and target and set the counter to 2 if taken; leave the entry untouched if not taken.
REQ-027 SHALL return the pre-update value when a same-cycle lookup and update hit the same index; the new value is visible from the next cycle.
REQ-028 SHALL increment mispred_cnt_o by 1 per mispredict cycle, saturating at 16'hFFFF.
REQ-029 SHALL leave res_* inputs ignored while res_valid_i = 0.

Reset
REQ-030 SHALL, with rst_i high at an edge, clear all valid bits, set all counters to 2'b01, and clear mispred_cnt_o to 0; targets and tags need no reset.
REQ-031 SHALL, while rst_i is high, force pc_write_o = 0 and flush_o = 0, and drive pc_next_o = 0 and pred_taken_o = 0.
REQ-032 SHALL discard any update pending in the same cycle as rst_i; reset wins over res_valid_i.

Verification
REQ-033 SHALL cover cold table: after reset, pc_i=0x100 -> pred_taken_o=0, pc_next_o=0x104, pc_write_o=1, flush_o=0.
REQ-034 SHALL cover train: resolve pc 0x100 taken to 0x200 with pred 0 -> flush_o=1, pc_next_o=0x200, count=1; next cycle pc_i=0x100 -> pred_taken_o=1, pred_target_o=0x200.
REQ-035 SHALL cover saturation: with the counter at 3, two not-taken resolves -> counter 1, prediction 0; a further not-taken leaves the counter at 0, not 3.
REQ-036 SHALL cover stall vs redirect: stall_i=1 alone -> pc_write_o=0, pc_next_o=pc_i; stall_i=1 with a not-taken mispredict at 0x300 -> pc_write_o=1, pc_next_o=0x304, flush_o=1.
REQ-037 SHALL cover the wrong-target case: pred taken to 0x200 but actual taken to 0x240 -> flush_o=1, pc_next_o=0x240, entry target becomes 0x240.
REQ-038 SHALL cover reset mid-operation: a trained entry plus rst_i=1 in the same cycle as res_valid_i -> next lookup misses and the counter reads 01.
